// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module : vend_pkg
// Brief  : Shared state encoding, coin indices/values for the vending control.
// Rev    : 1.0  initial release
// ============================================================================
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MANAGE = 3'd1,
        ST_CREDIT = 3'd2,
        ST_QTY    = 3'd3,
        ST_READY  = 3'd4,
        ST_MAKING = 3'd5,
        ST_SERVE  = 3'd6,
        ST_REFUND = 3'd7
    } vend_state_t;

    localparam int COIN50   = 0;
    localparam int COIN100  = 1;
    localparam int COIN500  = 2;
    localparam int COIN1000 = 3;

    // Values are in units of 50 won.
    localparam int unsigned VAL50   = 1;
    localparam int unsigned VAL100  = 2;
    localparam int unsigned VAL500  = 10;
    localparam int unsigned VAL1000 = 20;

    function automatic int unsigned coin_value(input int idx);
        case (idx)
            COIN50:   return VAL50;
            COIN100:  return VAL100;
            COIN500:  return VAL500;
            COIN1000: return VAL1000;
            default:  return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_disp.sv
`default_nettype none
// ============================================================================
// Module : vend_change_disp
// Brief  : Greedy change selector: largest coin not exceeding the credit.
// Rev    : 1.0  initial release
// ============================================================================
module vend_change_disp
    import vend_pkg::*;
#(
    parameter int SUM_W = 7
) (
    input  logic [SUM_W-1:0] sum,
    input  logic             enable,
    output logic [3:0]       ret_coin,
    output logic [SUM_W-1:0] dec
);

    always_comb begin
        ret_coin = '0;
        dec      = '0;
        if (enable) begin
            if (sum >= SUM_W'(VAL1000)) begin
                ret_coin[COIN1000] = 1'b1;
                dec                = SUM_W'(VAL1000);
            end else if (sum >= SUM_W'(VAL500)) begin
                ret_coin[COIN500] = 1'b1;
                dec               = SUM_W'(VAL500);
            end else if (sum >= SUM_W'(VAL100)) begin
                ret_coin[COIN100] = 1'b1;
                dec               = SUM_W'(VAL100);
            end else if (sum != '0) begin
                ret_coin[COIN50] = 1'b1;
                dec              = SUM_W'(VAL50);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vend_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : vend_ctrl_multi
// Brief  : Multi-drink, multi-cup coffee vending controller with greedy change.
// Rev    : 1.0  initial release
// ============================================================================
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int N_DRINK = 2,
    parameter int PRICE_W = 7,
    parameter int SUM_W   = 7,
    parameter int MAX_CUP = 5
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       Manage,
    input  logic                       Confirm,
    input  logic [N_DRINK*PRICE_W-1:0] Price_in,
    input  logic [3:0]                 Coin,
    input  logic [N_DRINK-1:0]         Sel,
    input  logic [MAX_CUP-1:0]         Cup,
    input  logic                       Start,
    input  logic                       Done,
    input  logic                       TakeOut,
    input  logic                       Return,
    output logic [3:0]                 Ret_coin,
    output logic                       Reject,
    output logic                       Making,
    output logic                       Coffee,
    output logic [SUM_W-1:0]           Sum,
    output logic [2:0]                 State
);

    localparam int CUP_W   = $clog2(MAX_CUP + 1);
    localparam int COST_W  = PRICE_W + CUP_W;
    localparam int CMP_W   = ((COST_W > SUM_W) ? COST_W : SUM_W) + 1;
    localparam int DRV_W   = (N_DRINK > 1) ? $clog2(N_DRINK) : 1;
    localparam int SUM_MAX = (1 << SUM_W) - 1;

    vend_state_t        r_state, w_state_n;
    logic [SUM_W-1:0]   r_sum, w_sum_n;
    logic [PRICE_W-1:0] r_price [N_DRINK];
    logic [DRV_W-1:0]   r_drink, w_drink_n;
    logic [COST_W-1:0]  r_cost, w_cost_n;
    logic [CUP_W-1:0]   r_qty, w_qty_n, r_cnt, w_cnt_n;
    logic               r_reject, w_reject_n, w_load_price;

    logic [5:0]         r_prev_ctl;
    logic [3:0]         r_prev_coin;
    logic [N_DRINK-1:0] r_prev_sel;
    logic [MAX_CUP-1:0] r_prev_cup;

    logic [5:0] w_ctl, w_ctl_e;
    logic       w_manage_e, w_confirm_e, w_start_e, w_done_e, w_take_e, w_return_e;
    logic [3:0] w_coin_e;
    logic       w_sel_e, w_cup_e;

    assign w_ctl      = {Manage, Confirm, Start, Done, TakeOut, Return};
    assign w_ctl_e    = w_ctl & ~r_prev_ctl;
    assign w_manage_e  = w_ctl_e[5];
    assign w_confirm_e = w_ctl_e[4];
    assign w_start_e   = w_ctl_e[3];
    assign w_done_e    = w_ctl_e[2];
    assign w_take_e    = w_ctl_e[1];
    assign w_return_e  = w_ctl_e[0];
    assign w_coin_e    = Coin & ~r_prev_coin;
    assign w_sel_e     = |(Sel & ~r_prev_sel);
    assign w_cup_e     = |(Cup & ~r_prev_cup);

    // Drink selection: only an available, affordable single drink is latched.
    logic [DRV_W-1:0] w_sel_idx;
    logic             w_sel_ok;
    always_comb begin
        w_sel_idx = '0;
        w_sel_ok  = 1'b0;
        if ($onehot(Sel)) begin
            for (int i = 0; i < N_DRINK; i++) begin
                if (Sel[i]) begin
                    w_sel_idx = DRV_W'(i);
                    w_sel_ok  = (r_price[i] != '0) &&
                                (CMP_W'(r_sum) >= CMP_W'(r_price[i]));
                end
            end
        end
    end

    logic [COST_W-1:0] w_cup_cost;
    logic [CUP_W-1:0]  w_cup_qty;
    logic              w_cup_ok;
    always_comb begin
        w_cup_cost = '0;
        w_cup_qty  = '0;
        for (int k = 0; k < MAX_CUP; k++) begin
            if (Cup[k]) begin
                w_cup_qty  = CUP_W'(k + 1);
                w_cup_cost = COST_W'(r_price[r_drink]) * COST_W'(k + 1);
            end
        end
        w_cup_ok = $onehot(Cup) && (CMP_W'(w_cup_cost) <= CMP_W'(r_sum));
    end

    logic [SUM_W-1:0] w_coin_val;
    logic             w_coin_any, w_coin_take, w_accept_state, w_hi_evt;
    always_comb begin
        w_coin_val = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_coin_e[i]) w_coin_val = SUM_W'(coin_value(i));
        end
    end

    // A coin loses to any higher-priority event landing in the same cycle.
    assign w_coin_any     = |w_coin_e;
    assign w_accept_state = (r_state == ST_IDLE) || (r_state == ST_CREDIT) ||
                            (r_state == ST_QTY)  || (r_state == ST_READY);
    assign w_hi_evt       = w_return_e | w_start_e | w_cup_e | w_sel_e | w_manage_e;
    assign w_coin_take    = w_coin_any && $onehot(w_coin_e) && w_accept_state &&
                            !w_hi_evt &&
                            ((CMP_W'(r_sum) + CMP_W'(w_coin_val)) <= CMP_W'(SUM_MAX));

    logic [SUM_W-1:0] w_dec;
    logic [CUP_W-1:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + CUP_W'(1);

    vend_change_disp #(.SUM_W(SUM_W)) u_change (
        .sum      (r_sum),
        .enable   (r_state == ST_REFUND),
        .ret_coin (Ret_coin),
        .dec      (w_dec)
    );

    always_comb begin
        w_state_n    = r_state;
        w_sum_n      = r_sum;
        w_drink_n    = r_drink;
        w_cost_n     = r_cost;
        w_qty_n      = r_qty;
        w_cnt_n      = r_cnt;
        w_load_price = 1'b0;
        w_reject_n   = w_coin_any & ~w_coin_take;
        if (w_coin_take) w_sum_n = r_sum + w_coin_val;

        case (r_state)
            ST_IDLE: begin
                if (w_manage_e)       w_state_n = ST_MANAGE;
                else if (w_coin_take) w_state_n = ST_CREDIT;
            end
            ST_MANAGE: begin
                if (w_confirm_e) begin
                    w_load_price = 1'b1;
                    w_state_n    = ST_IDLE;
                end
            end
            ST_CREDIT, ST_QTY, ST_READY: begin
                if (w_return_e) begin
                    w_state_n = (r_sum != '0) ? ST_REFUND : ST_IDLE;
                end else if (w_start_e && (r_state == ST_READY)) begin
                    w_sum_n   = r_sum - SUM_W'(r_cost);
                    w_cnt_n   = '0;
                    w_state_n = ST_MAKING;
                end else if (w_cup_e && (r_state == ST_QTY) && w_cup_ok) begin
                    w_cost_n  = w_cup_cost;
                    w_qty_n   = w_cup_qty;
                    w_state_n = ST_READY;
                end else if (w_sel_e && w_sel_ok) begin
                    w_drink_n = w_sel_idx;
                    w_state_n = ST_QTY;
                end
            end
            ST_MAKING: begin
                if (w_done_e) begin
                    w_cnt_n = w_cnt_inc;
                    if (w_cnt_inc == r_qty) w_state_n = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_take_e) w_state_n = (r_sum != '0) ? ST_CREDIT : ST_IDLE;
            end
            ST_REFUND: begin
                w_sum_n = r_sum - w_dec;
                if (w_sum_n == '0) w_state_n = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_drink     <= '0;
            r_cost      <= '0;
            r_qty       <= '0;
            r_cnt       <= '0;
            r_reject    <= 1'b0;
            r_prev_ctl  <= '0;
            r_prev_coin <= '0;
            r_prev_sel  <= '0;
            r_prev_cup  <= '0;
        end else begin
            r_state     <= w_state_n;
            r_sum       <= w_sum_n;
            r_drink     <= w_drink_n;
            r_cost      <= w_cost_n;
            r_qty       <= w_qty_n;
            r_cnt       <= w_cnt_n;
            r_reject    <= w_reject_n;
            r_prev_ctl  <= w_ctl;
            r_prev_coin <= Coin;
            r_prev_sel  <= Sel;
            r_prev_cup  <= Cup;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_DRINK; i++) begin
            if (RST)               r_price[i] <= '0;
            else if (w_load_price) r_price[i] <= Price_in[i*PRICE_W +: PRICE_W];
        end
    end

    assign Sum    = r_sum;
    assign State  = r_state;
    assign Reject = r_reject;
    assign Making = (r_state == ST_MAKING);
    assign Coffee = (r_state == ST_SERVE);

endmodule
`default_nettype wire

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised successor of the two-drink coffee vending controller. It supports N_DRINK drinks with a programmable price table and multi-cup orders of 1..MAX_CUP cups. Credit accumulates from four coin denominations; change is returned one coin per cycle using the largest coin first. It sits between the front-panel button/coin synchroniser and the brewer and dispenser actuators.

Parameters:
N_DRINK, 2, number of selectable drinks
PRICE_W, 7, width of one price entry (units of 50 won)
SUM_W, 7, credit register width (units of 50 won); SUM_MAX = 2**SUM_W-1
MAX_CUP, 5, maximum cups per order

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  reset; one clock; synchronous, active-high
Manage  in  1  enter price-programming mode
Confirm  in  1  commit Price_in to the price table
Price_in  in  N_DRINK*PRICE_W  flat price bus; drink i at [i*PRICE_W +: PRICE_W]
Coin  in  4  {1000,500,100,50} won coin-insert strobes, [0]=50
Sel  in  N_DRINK  one-hot drink select
Cup  in  MAX_CUP  one-hot cup count; Cup[k] means k+1 cups
Start  in  1  begin brewing
Done  in  1  brewer: one cup finished
TakeOut  in  1  customer removed the order
Return  in  1  refund request
Ret_coin  out  4  one-cycle change-coin pulses, same bit order as Coin
Reject  out  1  one-cycle pulse: coin refused
Making  out  1  brewer run
Coffee  out  1  order ready at the outlet
Sum  out  SUM_W  current credit (units of 50 won)
State  out  3  current FSM state, for debug

Behaviour:
- All control inputs are treated as levels. Internal rising-edge detection (one register stage) ensures a held level acts once. An event is the edge-detect cycle; its register updates are visible one cycle later.
- On RST: every output is 0, Sum=0, all prices=0 (no drink available), state IDLE, counters cleared. RST mid-order discards the credit and aborts brewing (Making drops next cycle).
- Coin values: 50→1, 100→2, 500→10, 1000→20.
- States: IDLE(0), MANAGE(1), CREDIT(2), QTY(3), READY(4), MAKING(5), SERVE(6), REFUND(7).
- IDLE: Manage event → MANAGE. A valid coin → CREDIT.
- MANAGE: Confirm event → all prices loaded from Price_in, then → IDLE. Coins are rejected in this state.
- Coin acceptance applies in IDLE, CREDIT, QTY and READY:
  - If Sum+value ≤ SUM_MAX, Sum += value.
  - If the sum would exceed SUM_MAX, or more than one Coin bit has an edge in the same cycle, the coin is refused: Reject pulses once and Sum is unchanged.
  - Coins in any other state are refused with Reject.
- CREDIT: Sel event with exactly one bit set, price[i]≠0 and Sum≥price[i] → latch the drink, → QTY. Any other Sel is ignored.
- QTY: Cup[k] event (one-hot) with cost=price*(k+1) ≤ Sum → latch cost and qty, → READY. Otherwise ignored. Cost is computed at PRICE_W+3 bits with no truncation.
- READY: Start event → Sum -= cost, Making=1, cup count=0, → MAKING. A new Sel in QTY or READY returns to the QTY step with the new drink.
- MAKING: each Done event increments the cup count. When count==qty: Making=0, Coffee=1, → SERVE. Done in any other state is ignored.
- SERVE: TakeOut event → Coffee=0. Then → CREDIT if Sum>0, else IDLE.
- Return event in CREDIT, QTY or READY with Sum>0 → REFUND. Return is ignored in MAKING, SERVE and MANAGE. Return with Sum=0 → IDLE.
- REFUND: each cycle, pulse the Ret_coin bit of the largest coin ≤ Sum and subtract its value. When Sum reaches 0 → IDLE, one cycle after the last pulse. Coin inputs during REFUND are rejected.
- Simultaneous events, priority: Return > Start > Cup > Sel > Coin. Coin and Return in the same cycle: the coin is rejected.

Decomposition:
- Package vend_pkg holds: the state enum; coin index constants (COIN50..COIN1000); coin value constants; a function coin_value(idx).
- One sub-module, vend_change_disp, implements the greedy refund: inputs Sum and enable, outputs the Ret_coin pulse and the decrement value.

Test Plan:
1. Program Price_in={6,4}, Confirm. Insert 3×Coin[1] → Sum=6. Sel[0], Cup[0], Start → Sum=2, Making=1. Done → Coffee=1. TakeOut → CREDIT. Return → one Ret_coin[1] pulse, Sum=0, IDLE.
2. Sum=6, Sel[1] (price 6), Cup[1] (cost 12) → ignored, stays QTY. Cup[0] → READY. Start, then 1 Done → SERVE, Sum=0.
3. Multi-cup: Coin[3] → Sum=20. Sel[0], Cup[2] (cost 12), Start → Sum=8. Two Done → Making still 1. Third Done → Coffee=1.
4. Overflow: Sum=120, Coin[3] → Reject pulse, Sum stays 120. Coin[0]|Coin[1] in the same cycle → Reject, Sum unchanged.
5. Refund of Sum=33 → pulses 1000,500,100,50 over 4 consecutive cycles (20+10+2+1). Sum=0 the cycle after. Return during MAKING → ignored.
6. RST asserted mid-MAKING → Making=0, Sum=0, prices=0 next cycle. Subsequent Sel with Sum>0 is ignored because price=0.
